rrat: RTL and testbench
=======================

Name: rrat

Overview:
- Retirement register alias table. Sits downstream of the ROB retire port and alongside the rename-stage RAT.
- Holds the committed arch-to-phys mapping and the committed PRF free list.
- Produces the restore image (`rrat_entries`, `rrat_free_list`) that the RAT loads on nuke.
- Produces the per-cycle `free_vector` that returns superseded phys regs to the RAT free list.

Parameters:
- N, 2, retire width (instructions per cycle).
- RAT_SIZE, 32, number of architectural registers.
- PRF_NUM_ENTRIES, 64, number of physical registers.
- REG_INDEX_BITS, 5, log2(RAT_SIZE).
- PRF_NUM_INDEX_BITS, 6, log2(PRF_NUM_ENTRIES).

Ports:
- clock  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- retire_valid  input  N  slot i retires this cycle; slot 0 is oldest.
- retire_dest_valid  input  N  slot i writes a destination register.
- retire_arch_reg  input  N x REG_INDEX_BITS  destination arch reg of slot i.
- retire_phys_reg  input  N x PRF_NUM_INDEX_BITS  phys reg allocated to slot i at rename.
- rrat_entries  output  RAT_SIZE x PRF_NUM_INDEX_BITS  committed mapping (registered).
- rrat_free_list  output  PRF_NUM_ENTRIES  committed free list, 1 = free (registered).
- free_vector  output  PRF_NUM_ENTRIES  phys regs released by last cycle's retirement (registered, one-cycle pulse).
- free_count  output  PRF_NUM_INDEX_BITS+1  popcount of rrat_free_list (registered).
- retire_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (sync, has priority over all other activity):
  - rrat_entries = all 0.
  - rrat_free_list = all 1.
  - free_vector = 0.
  - free_count = PRF_NUM_ENTRIES.
  - retire_err = 0.
  - Reset asserted mid-retirement discards that cycle's retirements.
- Effective slot: retire_valid[i] && retire_dest_valid[i] && retire_arch_reg[i] != 0. Non-effective slots change nothing.
- Processing order: effective slots are processed in order 0..N-1 in one combinational pass against a working copy of the table and free list. For each effective slot i:
  - p_old = working_table[arch].
  - working_table[arch] = p_new.
  - working_free[p_new] = 0.
  - If p_old != 0: working_free[p_old] = 1 and next_free_vector[p_old] = 1.
- Same-cycle, same arch reg: an older slot's p_new becomes the younger slot's p_old and is freed in the same cycle.
  - End state: table holds the youngest p_new; the older p_new is free and appears in free_vector.
- Phys reg 0 is the reset mapping of every arch reg. It is never reported in free_vector and never set free by retirement.
- Latency: all updates visible one cycle after the retiring edge.
  - rrat_entries, rrat_free_list, free_vector, free_count all update on the same edge.
  - free_count reflects the updated rrat_free_list.
  - free_vector is 0 in any cycle following a cycle with no effective slot.
- Nuke handshake: no nuke input. The ROB asserts nuke to the RAT the cycle after the mispredicting instruction retires, so the registered outputs already include it. The RAT consumes rrat_entries/rrat_free_list directly.
- free_vector must not double-report: a phys reg appears at most once per cycle.
- retire_err is set (sticky until reset) if any effective slot has either:
  - retire_phys_reg == 0, or
  - working_free[p_new] == 0 at the moment that slot is processed (phys reg already committed live).
  - The offending retirement is still applied.
- A non-effective slot between effective slots (e.g. slot 0 invalid, slot 1 valid) is legal. No retirement ordering requirement is checked.
- The table never changes on arch reg 0; rrat_entries[0] stays 0 forever.

Test Plan:
- Reset, no retirements for 5 cycles -> rrat_entries all 0, rrat_free_list = all 1, free_count = 64, free_vector = 0, retire_err = 0.
- Cycle 1: slot0 arch 3 -> p5. Cycle 2: slot0 arch 3 -> p9.
  - After cycle 1: entries[3] = 5, free_list[5] = 0, free_count = 63, free_vector = 0 (p_old = 0).
  - After cycle 2: entries[3] = 9, free_list[5] = 1, free_list[9] = 0, free_vector = bit 5 only, free_count = 63.
  - Next idle cycle: free_vector = 0.
- Same cycle: slot0 arch 7 -> p12, slot1 arch 7 -> p13 (entries[7] previously p4) -> entries[7] = 13; free_vector = bits 4 and 12; free_list[13] = 0, [12] = 1, [4] = 1.
- Ignored slots:
  - slot0 arch 0 -> p20 with dest_valid = 1 -> no change.
  - slot1 arch 6 -> p21 with retire_valid = 1, dest_valid = 0 -> no change.
  - Both cases: free_vector = 0, entries[0] = 0.
- Error cases:
  - Retire arch 2 -> p5 while p5 is mapped to arch 3 -> retire_err = 1 next cycle and stays 1; entries[2] = 5.
  - Assert reset -> retire_err = 0.
- Reset mid-operation: assert reset in the same cycle as slot0 arch 1 -> p30 -> next cycle entries[1] = 0, free_list all 1, free_vector = 0.

Source files
------------

// File: rtl/rrat.sv
// rrat -- retirement register alias table.
//
// Holds the committed arch-to-phys mapping and the committed physical
// register free list. Retiring instructions that write a destination
// replace the committed mapping of their arch register. The phys reg they
// displace is returned to the free list and reported in free_vector.
// All outputs are registered and update on the edge that follows the
// retiring cycle.
//
// Ports:
//   clock, reset        clock; synchronous active-high reset
//   retire_valid        [N]     slot i retires this cycle (slot 0 oldest)
//   retire_dest_valid   [N]     slot i writes a destination register
//   retire_arch_reg     [N*5]   destination arch reg per slot
//   retire_phys_reg     [N*6]   phys reg allocated to the slot at rename
//   rrat_entries        [32*6]  committed mapping; entry a is at [a*6 +: 6]
//   rrat_free_list      [64]    committed free list, 1 = free
//   free_vector         [64]    phys regs released by the last cycle (pulse)
//   free_count          [7]     popcount of rrat_free_list
//   retire_err          [1]     sticky protocol-violation flag
//
// Handshake: there is no back-pressure. A slot is consumed in the cycle it
// is presented. A slot is effective when it is valid, writes a destination,
// and that destination is not arch reg 0. Non-effective slots are ignored.
module rrat #(
  parameter int N                  = 2,
  parameter int RAT_SIZE           = 32,
  parameter int PRF_NUM_ENTRIES    = 64,
  parameter int REG_INDEX_BITS     = 5,
  parameter int PRF_NUM_INDEX_BITS = 6
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [N-1:0]                           retire_valid,
  input  logic [N-1:0]                           retire_dest_valid,
  input  logic [N*REG_INDEX_BITS-1:0]            retire_arch_reg,
  input  logic [N*PRF_NUM_INDEX_BITS-1:0]        retire_phys_reg,
  output logic [RAT_SIZE*PRF_NUM_INDEX_BITS-1:0] rrat_entries,
  output logic [PRF_NUM_ENTRIES-1:0]             rrat_free_list,
  output logic [PRF_NUM_ENTRIES-1:0]             free_vector,
  output logic [PRF_NUM_INDEX_BITS:0]            free_count,
  output logic                                   retire_err
);

  localparam int CNT_W = PRF_NUM_INDEX_BITS + 1;

  logic [RAT_SIZE-1:0][PRF_NUM_INDEX_BITS-1:0] r_table;
  logic [PRF_NUM_ENTRIES-1:0]                  r_free;
  logic [PRF_NUM_ENTRIES-1:0]                  r_free_vector;
  logic [CNT_W-1:0]                            r_free_count;
  logic                                        r_err;

  // Per-slot decode.
  logic [N-1:0]                    w_eff;
  logic [REG_INDEX_BITS-1:0]       w_arch [N];
  logic [PRF_NUM_INDEX_BITS-1:0]   w_pnew [N];
  logic [PRF_NUM_INDEX_BITS-1:0]   w_pold [N];

  // Working copies after all slots of this cycle are applied.
  logic [RAT_SIZE-1:0][PRF_NUM_INDEX_BITS-1:0] w_table;
  logic [PRF_NUM_ENTRIES-1:0]                  w_free;
  logic [PRF_NUM_ENTRIES-1:0]                  w_free_vector;
  logic [CNT_W-1:0]                            w_free_count;
  logic                                        w_err;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_arch[i] = retire_arch_reg[i*REG_INDEX_BITS +: REG_INDEX_BITS];
      w_pnew[i] = retire_phys_reg[i*PRF_NUM_INDEX_BITS +: PRF_NUM_INDEX_BITS];
      w_eff[i]  = retire_valid[i] && retire_dest_valid[i] && (w_arch[i] != '0);
    end
  end

  // Slots are walked oldest first against the working copy. A younger slot
  // to the same arch reg therefore sees the older slot's phys reg as its
  // previous mapping, and frees it in the same cycle. free_vector is a bit
  // vector, so a phys reg can never be reported twice.
  always_comb begin
    w_table       = r_table;
    w_free        = r_free;
    w_free_vector = '0;
    w_err         = r_err;
    for (int i = 0; i < N; i++) begin
      w_pold[i] = '0;
      if (w_eff[i]) begin
        w_pold[i] = w_table[w_arch[i]];
        // A zero phys reg, or one that is already committed live, is a
        // protocol violation. The retirement is still applied.
        if (w_pnew[i] == '0 || !w_free[w_pnew[i]]) begin
          w_err = 1'b1;
        end
        w_table[w_arch[i]] = w_pnew[i];
        w_free[w_pnew[i]]  = 1'b0;
        // Phys reg 0 is the reset mapping and is never released.
        if (w_pold[i] != '0) begin
          w_free[w_pold[i]]        = 1'b1;
          w_free_vector[w_pold[i]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_free_count = '0;
    for (int j = 0; j < PRF_NUM_ENTRIES; j++) begin
      w_free_count = w_free_count + CNT_W'(w_free[j]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_table       <= '0;
      r_free        <= '1;
      r_free_vector <= '0;
      r_free_count  <= CNT_W'(PRF_NUM_ENTRIES);
      r_err         <= 1'b0;
    end else begin
      r_table       <= w_table;
      r_free        <= w_free;
      r_free_vector <= w_free_vector;
      r_free_count  <= w_free_count;
      r_err         <= w_err;
    end
  end

  assign rrat_entries   = r_table;
  assign rrat_free_list = r_free;
  assign free_vector    = r_free_vector;
  assign free_count     = r_free_count;
  assign retire_err     = r_err;

endmodule

// File: tb/tb_rrat.sv
module tb_rrat;

  localparam int N   = 2;
  localparam int RS  = 32;
  localparam int PE  = 64;
  localparam int RB  = 5;
  localparam int PB  = 6;

  logic             clock;
  logic             reset;
  logic [N-1:0]     retire_valid;
  logic [N-1:0]     retire_dest_valid;
  logic [N*RB-1:0]  retire_arch_reg;
  logic [N*PB-1:0]  retire_phys_reg;
  logic [RS*PB-1:0] rrat_entries;
  logic [PE-1:0]    rrat_free_list;
  logic [PE-1:0]    free_vector;
  logic [PB:0]      free_count;
  logic             retire_err;

  rrat dut (
    .clock             (clock),
    .reset             (reset),
    .retire_valid      (retire_valid),
    .retire_dest_valid (retire_dest_valid),
    .retire_arch_reg   (retire_arch_reg),
    .retire_phys_reg   (retire_phys_reg),
    .rrat_entries      (rrat_entries),
    .rrat_free_list    (rrat_free_list),
    .free_vector       (free_vector),
    .free_count        (free_count),
    .retire_err        (retire_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: mapping per arch reg, set of live phys regs,
  // and the set of phys regs released by the last cycle.
  int m_map [RS];
  bit m_live [PE];
  int m_released [$];
  bit m_err;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [RS*PB-1:0] exp_entries();
    logic [RS*PB-1:0] v;
    v = '0;
    for (int a = 0; a < RS; a++) v[a*PB +: PB] = PB'(m_map[a]);
    return v;
  endfunction

  function automatic logic [PE-1:0] exp_free();
    logic [PE-1:0] v;
    for (int p = 0; p < PE; p++) v[p] = !m_live[p];
    return v;
  endfunction

  function automatic logic [PE-1:0] exp_fv();
    logic [PE-1:0] v;
    v = '0;
    foreach (m_released[k]) v[m_released[k]] = 1'b1;
    return v;
  endfunction

  function automatic int exp_count();
    int c;
    c = 0;
    for (int p = 0; p < PE; p++) if (!m_live[p]) c++;
    return c;
  endfunction

  // Model update on the retiring edge. Reset starts with nothing live.
  always @(posedge clock) begin
    if (reset) begin
      for (int a = 0; a < RS; a++) m_map[a] = 0;
      for (int p = 0; p < PE; p++) m_live[p] = 1'b0;
      m_released.delete();
      m_err = 1'b0;
    end else begin
      m_released.delete();
      for (int i = 0; i < N; i++) begin
        int a, p, old;
        a = int'(retire_arch_reg[i*RB +: RB]);
        p = int'(retire_phys_reg[i*PB +: PB]);
        if (retire_valid[i] && retire_dest_valid[i] && a != 0) begin
          old = m_map[a];
          if (p == 0 || m_live[p]) m_err = 1'b1;
          m_map[a] = p;
          m_live[p] = 1'b1;
          if (old != 0) begin
            m_live[old] = 1'b0;
            m_released.push_back(old);
          end
        end
      end
    end
  end

  // Compare process: outputs are compared against the model every cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      check("entries",    256'(rrat_entries),   256'(exp_entries()));
      check("free_list",  256'(rrat_free_list), 256'(exp_free()));
      check("free_vector",256'(free_vector),    256'(exp_fv()));
      check("free_count", 256'(free_count),     256'(exp_count()));
      check("retire_err", 256'(retire_err),     256'(m_err));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic [1:0] v, input logic [1:0] dv,
                      input int a0, input int p0, input int a1, input int p1);
    reset             = rst;
    retire_valid      = v;
    retire_dest_valid = dv;
    retire_arch_reg   = {RB'(a1), RB'(a0)};
    retire_phys_reg   = {PB'(p1), PB'(p0)};
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00, 2'b00, 0, 0, 0, 0);
  endtask

  function automatic logic [PB-1:0] ent(input int a);
    return rrat_entries[a*PB +: PB];
  endfunction

  function automatic logic [PE-1:0] bit_of(input int p);
    logic [PE-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    step(1'b1, 2'b00, 2'b00, 0, 0, 0, 0);
    step(1'b1, 2'b00, 2'b00, 0, 0, 0, 0);
    chk_en = 1'b1;
    idle(5);
    check("rst_entries", 256'(rrat_entries),   256'(0));
    check("rst_free",    256'(rrat_free_list), 256'({PE{1'b1}}));
    check("rst_count",   256'(free_count),     256'(64));
    check("rst_fv",      256'(free_vector),    256'(0));
    check("rst_err",     256'(retire_err),     256'(0));

    // arch 3 -> p5, then arch 3 -> p9
    step(1'b0, 2'b01, 2'b01, 3, 5, 0, 0);
    check("a3_p5_ent",   256'(ent(3)),            256'(5));
    check("a3_p5_fl5",   256'(rrat_free_list[5]), 256'(0));
    check("a3_p5_cnt",   256'(free_count),        256'(63));
    check("a3_p5_fv",    256'(free_vector),       256'(0));
    step(1'b0, 2'b01, 2'b01, 3, 9, 0, 0);
    check("a3_p9_ent",   256'(ent(3)),            256'(9));
    check("a3_p9_fl5",   256'(rrat_free_list[5]), 256'(1));
    check("a3_p9_fl9",   256'(rrat_free_list[9]), 256'(0));
    check("a3_p9_fv",    256'(free_vector),       256'(bit_of(5)));
    check("a3_p9_cnt",   256'(free_count),        256'(63));
    idle(1);
    check("idle_fv",     256'(free_vector),       256'(0));

    // arch 7 -> p4, then same-cycle arch 7 -> p12, arch 7 -> p13
    step(1'b0, 2'b01, 2'b01, 7, 4, 0, 0);
    check("a7_p4_cnt",   256'(free_count),        256'(62));
    step(1'b0, 2'b11, 2'b11, 7, 12, 7, 13);
    check("a7_ent",      256'(ent(7)),            256'(13));
    check("a7_fv",       256'(free_vector),       256'(bit_of(4) | bit_of(12)));
    check("a7_fl13",     256'(rrat_free_list[13]),256'(0));
    check("a7_fl12",     256'(rrat_free_list[12]),256'(1));
    check("a7_fl4",      256'(rrat_free_list[4]), 256'(1));
    check("a7_cnt",      256'(free_count),        256'(62));

    // ignored slots: arch 0 with dest, and valid slot without dest
    step(1'b0, 2'b11, 2'b01, 0, 20, 6, 21);
    check("ign_fv",      256'(free_vector),       256'(0));
    check("ign_e0",      256'(ent(0)),            256'(0));
    check("ign_e6",      256'(ent(6)),            256'(0));
    check("ign_fl20",    256'(rrat_free_list[20]),256'(1));
    check("ign_fl21",    256'(rrat_free_list[21]),256'(1));

    // two different arch regs in one cycle
    step(1'b0, 2'b11, 2'b11, 1, 30, 2, 31);
    check("pair_e1",     256'(ent(1)),            256'(30));
    check("pair_e2",     256'(ent(2)),            256'(31));
    check("pair_cnt",    256'(free_count),        256'(60));

    // error: arch 3 back to p5 (legal), then arch 2 -> p5 (p5 already live)
    step(1'b0, 2'b01, 2'b01, 3, 5, 0, 0);
    check("pre_err",     256'(retire_err),        256'(0));
    step(1'b0, 2'b01, 2'b01, 2, 5, 0, 0);
    check("err_set",     256'(retire_err),        256'(1));
    check("err_e2",      256'(ent(2)),            256'(5));
    check("err_fv",      256'(free_vector),       256'(bit_of(31)));
    idle(3);
    check("err_sticky",  256'(retire_err),        256'(1));

    // reset in the same cycle as a retirement: retirement discarded
    step(1'b1, 2'b01, 2'b01, 1, 30, 0, 0);
    check("rmid_e1",     256'(ent(1)),            256'(0));
    check("rmid_free",   256'(rrat_free_list),    256'({PE{1'b1}}));
    check("rmid_fv",     256'(free_vector),       256'(0));
    check("rmid_err",    256'(retire_err),        256'(0));

    // slot 0 idle, slot 1 retires phys reg 0: flagged, still applied
    step(1'b0, 2'b10, 2'b10, 0, 0, 4, 0);
    check("p0_err",      256'(retire_err),        256'(1));
    check("p0_fv",       256'(free_vector),       256'(0));
    step(1'b0, 2'b10, 2'b10, 0, 0, 4, 40);
    check("p0_e4",       256'(ent(4)),            256'(40));
    check("p0_fv2",      256'(free_vector),       256'(0));
    step(1'b1, 2'b00, 2'b00, 0, 0, 0, 0);
    check("clr_err",     256'(retire_err),        256'(0));
    idle(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
